// File: rtl/race_flow_if.sv
// race_flow_if: frame/button/datapath inputs and round-control outputs
// of the stock-car game-flow sequencer.
interface race_flow_if;
  logic       frame_tick;
  logic       start_btn;
  logic       collision;
  logic       obstacle_passed;
  logic       rescue_done;
  logic [2:0] state;
  logic       run_en;
  logic       obstacle_step;
  logic       line_step;
  logic       rescue_start;
  logic [1:0] countdown;
  logic [9:0] score;
  logic [1:0] lives;
  logic [1:0] level;

  modport master (
    input  frame_tick, start_btn, collision,
    input  obstacle_passed, rescue_done,
    output state, run_en, obstacle_step,
    output line_step, rescue_start, countdown,
    output score, lives, level
  );

  modport slave (
    output frame_tick, start_btn, collision,
    output obstacle_passed, rescue_done,
    input  state, run_en, obstacle_step,
    input  line_step, rescue_start, countdown,
    input  score, lives, level
  );
endinterface

// File: rtl/race_flow_controller.sv
// race_flow_controller: frame-locked round sequencer for the stock-car game.
// Define RACE_SPEEDUP_EN to build the level point counter and faster periods.
module race_flow_controller #(
  parameter int LIVES           = 3,
  parameter int COUNT_FRAMES    = 60,
  parameter int CRASH_FRAMES    = 60,
  parameter int BASE_PERIOD     = 4,
  parameter int SCORE_PER_LEVEL = 16
) (
  input logic         pclk,
  input logic         reset,
  race_flow_if.master bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    CRASH     = 3'd3,
    RESCUE    = 3'd4,
    OVER      = 3'd5
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] CRASH_LAST = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0] BASE       = 8'(BASE_PERIOD);
  localparam logic [9:0] SCORE_MAX  = 10'd999;

  state_t     st;
  logic       start_q;
  logic       run_en_q;
  logic       obst_q;
  logic       line_q;
  logic       resc_q;
  logic [1:0] countdown_q;
  logic [9:0] score_q;
  logic [1:0] lives_q;
  logic [1:0] level_q;
  logic [7:0] frame_cnt;
  logic [7:0] step_cnt;
  logic [7:0] period;
  logic [7:0] period_next;
  logic       start_rise;

`ifdef RACE_SPEEDUP_EN
  localparam logic [7:0] PTS_LAST = 8'(SCORE_PER_LEVEL - 1);
  logic [7:0] pts;
`else
  localparam int unused_spl = SCORE_PER_LEVEL;
`endif

  assign start_rise  = bus.start_btn & ~start_q;
  assign period_next = BASE - {6'd0, level_q};

  always_ff @(posedge pclk) begin
    if (reset) begin
      st          <= IDLE;
      start_q     <= 1'b0;
      run_en_q    <= 1'b0;
      obst_q      <= 1'b0;
      line_q      <= 1'b0;
      resc_q      <= 1'b0;
      countdown_q <= 2'd0;
      score_q     <= 10'd0;
      lives_q     <= 2'(LIVES);
      level_q     <= 2'd0;
      frame_cnt   <= 8'd0;
      step_cnt    <= 8'd0;
      period      <= BASE;
`ifdef RACE_SPEEDUP_EN
      pts         <= 8'd0;
`endif
    end else begin
      start_q <= bus.start_btn;
      obst_q  <= 1'b0;
      line_q  <= 1'b0;
      resc_q  <= 1'b0;
      unique case (st)
        IDLE, OVER: begin
          if (start_rise) begin
            st          <= COUNTDOWN;
            countdown_q <= 2'd3;
            frame_cnt   <= 8'd0;
            score_q     <= 10'd0;
            lives_q     <= 2'(LIVES);
            level_q     <= 2'd0;
`ifdef RACE_SPEEDUP_EN
            pts         <= 8'd0;
`endif
          end
        end
        COUNTDOWN: begin
          if (bus.frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
              frame_cnt <= 8'd0;
              if (countdown_q == 2'd1) begin
                st          <= RUN;
                run_en_q    <= 1'b1;
                countdown_q <= 2'd0;
                step_cnt    <= 8'd0;
                period      <= period_next;
              end else begin
                countdown_q <= countdown_q - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          if (bus.collision) begin
            st        <= CRASH;
            run_en_q  <= 1'b0;
            lives_q   <= lives_q - 2'd1;
            frame_cnt <= 8'd0;
          end else if (bus.frame_tick) begin
            line_q <= 1'b1;
            // new level's period is latched only when the step counter wraps
            if (step_cnt == period - 8'd1) begin
              obst_q   <= 1'b1;
              step_cnt <= 8'd0;
              period   <= period_next;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
          if (bus.obstacle_passed) begin
            if (score_q != SCORE_MAX) score_q <= score_q + 10'd1;
`ifdef RACE_SPEEDUP_EN
            if (pts == PTS_LAST) begin
              pts <= 8'd0;
              if (level_q != 2'd3) level_q <= level_q + 2'd1;
            end else begin
              pts <= pts + 8'd1;
            end
`endif
          end
        end
        CRASH: begin
          if (bus.frame_tick) begin
            if (frame_cnt == CRASH_LAST) begin
              st     <= RESCUE;
              resc_q <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        RESCUE: begin
          if (bus.rescue_done) begin
            if (lives_q == 2'd0) begin
              st <= OVER;
            end else begin
              st          <= COUNTDOWN;
              countdown_q <= 2'd3;
              frame_cnt   <= 8'd0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state         = st;
  assign bus.run_en        = run_en_q;
  assign bus.obstacle_step = obst_q;
  assign bus.line_step     = line_q;
  assign bus.rescue_start  = resc_q;
  assign bus.countdown     = countdown_q;
  assign bus.score         = score_q;
  assign bus.lives         = lives_q;
  assign bus.level         = level_q;
endmodule

// File: doc/race_flow_controller.md
# race_flow_controller

Game-flow sequencer for the stock-car VGA game. It owns the round state machine (idle, countdown, run, crash, rescue, game over) and derives the per-frame step strobes that advance obstacles and lane markings. It also tracks score, lives and speed level. It sits between the VGA timing generator (frame tick), the player buttons and the game datapath (collision, obstacle wrap, ambulance done), replacing free-running clock dividers with frame-locked scheduling.

## Interface
Parameters:
- LIVES, 3: lives per game; range 1..3.
- COUNT_FRAMES, 60: frame ticks per countdown digit.
- CRASH_FRAMES, 60: frame ticks frozen after a collision before rescue starts.
- BASE_PERIOD, 4: frame ticks per obstacle step at level 0; must be ≥ 4.
- SCORE_PER_LEVEL, 16: obstacles passed per level increment.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, at vblank start.
- start_btn  in  1  start button level, already synchronized; the block detects the rising edge internally.
- collision  in  1  level from datapath; car overlaps an obstacle.
- obstacle_passed  in  1  one-cycle pulse when an obstacle wraps off-screen.
- rescue_done  in  1  one-cycle pulse when the ambulance sequence completes.
- state  out  3  IDLE=0, COUNTDOWN=1, RUN=2, CRASH=3, RESCUE=4, OVER=5.
- run_en  out  1  high only in RUN; gates car movement in the datapath.
- obstacle_step  out  1  one-cycle pulse; advance obstacles one step.
- line_step  out  1  one-cycle pulse; scroll lane markings one step.
- rescue_start  out  1  one-cycle pulse; launch the ambulance.
- countdown  out  2  digit shown during COUNTDOWN (3, 2, 1); 0 in all other states.
- score  out  10  obstacles passed; saturates at 999.
- lives  out  2  remaining lives.
- level  out  2  speed level 0..3.

## Operation
- **IDLE:** a start_btn rising edge (current=1, previous=0) moves to COUNTDOWN and initializes the game: score=0, lives=LIVES, level=0, level point counter=0.
- **COUNTDOWN:** the frame counter counts frame_ticks.
  - countdown=3 for the first COUNT_FRAMES ticks, then 2, then 1.
  - On the 3·COUNT_FRAMES-th tick the block moves to RUN and clears the step counter.
- **RUN:**
  - Every frame_tick produces a line_step pulse.
  - The step counter counts frame_ticks from 0 to P−1, where P = BASE_PERIOD − level. When the counter is at P−1 on a tick, obstacle_step pulses and the counter wraps to 0.
  - A level change takes effect at the next wrap.
- **Scoring:** each obstacle_passed pulse in RUN adds 1 to score, saturating at 999. obstacle_passed is ignored in other states.
- **Collision:** collision=1 in any RUN cycle moves to CRASH and decrements lives by 1. No obstacle_step or line_step pulse is issued in that cycle, even if frame_tick is also high.
- **CRASH:** the block counts CRASH_FRAMES frame_ticks, then moves to RESCUE. rescue_start pulses on the same edge that enters RESCUE.
- **RESCUE:** rescue_done moves to OVER if lives==0; otherwise to COUNTDOWN. Score and level are preserved. rescue_done is ignored in other states.
- **OVER:** a start_btn rising edge behaves as in IDLE (fresh game, COUNTDOWN).
- **Simultaneous events:**
  - collision and obstacle_passed in the same cycle: score increments and the block still enters CRASH.
  - A start_btn edge in any state other than IDLE or OVER is ignored.
  - A held button does not retrigger; a fresh rising edge is required.
- **Reset:** at any point, including mid-countdown or mid-rescue, all state returns to reset values at the next edge. The edge detector's previous value is cleared to 0.

## Timing
- All outputs are registered.
- Values on reset: state=IDLE, run_en=0, all pulses 0, countdown=0, score=0, lives=LIVES, level=0.
- Step pulses assert exactly one cycle after the frame_tick that causes them.
- A state change is visible one cycle after its cause.
- run_en falls on the same edge that makes state=CRASH.
- Frame and step counters advance only on frame_tick cycles. Counters are 8 bits wide.

## Configuration
- **RACE_SPEEDUP_EN defined:**
  - A point counter counts obstacle_passed pulses in RUN.
  - When the counter reaches SCORE_PER_LEVEL, level increments (saturating at 3) and the counter clears.
  - The obstacle period shrinks with level, from BASE_PERIOD down to BASE_PERIOD−3.
- **RACE_SPEEDUP_EN undefined:** level is held at 0, the obstacle period is fixed at BASE_PERIOD, and no point counter is built.

## Test plan
- **Start and countdown:** reset, then pulse start_btn, then 180 frame_ticks (COUNT_FRAMES=60). Required: countdown sequences 3→2→1; state=RUN one cycle after tick 180; run_en=1.
- **Step scheduling at level 0:** 12 frame_ticks in RUN (BASE_PERIOD=4). Required: 12 line_step pulses and 3 obstacle_step pulses, each one cycle after its tick.
- **Crash and rescue with lives left:** collision in the same cycle as frame_tick during RUN. Required: no step pulse; state=CRASH; lives goes 3→2. After 60 ticks, rescue_start pulses once. On rescue_done, state=COUNTDOWN and score is unchanged.
- **Game over and restart:** lives=1, then collision, then rescue_done. Required: state=OVER. Holding start_btn high does nothing; a new rising edge starts a fresh game with score=0 and lives=3.
- **Speed-up with RACE_SPEEDUP_EN:** 16 obstacle_passed pulses. Required: level=1, and after the next wrap obstacle_step fires every 3 ticks. With 998 preloaded, 2 more pulses leave score=999.
- **Mid-rescue reset:** assert reset during RESCUE. Required: next cycle state=IDLE with all outputs at their reset values.
